// File: rtl/countdown_sequencer_pkg.sv
// rtl/countdown_sequencer_pkg.sv - shared state encoding and default sizing for countdown_sequencer
package countdown_sequencer_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_PS_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// rtl/countdown_sequencer_if.sv - command valid/ready channel into countdown_sequencer
interface countdown_sequencer_if
  import countdown_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             cmd_valid;
  logic [WIDTH-1:0] cmd_value;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_value, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_value, output cmd_ready);

endinterface

// File: rtl/countdown_sequencer_dec_prescaler.sv
// rtl/countdown_sequencer_dec_prescaler.sv - wrap counter pacing the decrement strobes
module countdown_sequencer_dec_prescaler
  import countdown_sequencer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PS_W     = DEF_PS_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + PS_W'(1);
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// rtl/countdown_sequencer.sv - command-driven controller for the 4-bit down counter stage
// Optional abort/aborted ports are built when COUNTDOWN_SEQ_ABORT_EN is defined.
module countdown_sequencer
  import countdown_sequencer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PS_W     = DEF_PS_W
) (
  input  logic                 clock,
  input  logic                 reset,
  countdown_sequencer_if.slave cmd,
  output logic [WIDTH-1:0]     cnt_in,
  output logic                 cnt_latch,
  output logic                 cnt_dec,
  input  logic                 cnt_zero,
  output logic                 busy,
`ifdef COUNTDOWN_SEQ_ABORT_EN
  input  logic                 abort,
  output logic                 aborted,
`endif
  output logic                 done
);

  state_t           state, state_nxt;
  logic             pending_valid;
  logic [WIDTH-1:0] pending_value;
  logic [WIDTH-1:0] value_reg;
  logic             accept;
  logic             abort_hit;
  logic             tick;

  assign cmd.cmd_ready = !pending_valid;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cnt_in        = value_reg;

`ifdef COUNTDOWN_SEQ_ABORT_EN
  assign abort_hit = abort && (state inside {ST_LOAD, ST_SETTLE, ST_RUN});
`else
  assign abort_hit = 1'b0;
`endif

  countdown_sequencer_dec_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state == ST_SETTLE) || abort_hit),
    .enable (state == ST_RUN),
    .tick   (tick)
  );

  always_comb begin
    state_nxt = state;
    cnt_latch = 1'b0;
    cnt_dec   = 1'b0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    case (state)
      ST_IDLE:   if (pending_valid || accept) state_nxt = ST_LOAD;
      ST_LOAD: begin
        cnt_latch = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: state_nxt = ST_RUN;
      ST_RUN: begin
        // zero gates dec so the counter can never be pushed past 0
        cnt_dec = tick && !cnt_zero;
        if (cnt_zero) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort_hit) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      pending_valid <= 1'b0;
      pending_value <= '0;
      value_reg     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_LOAD) begin
        value_reg <= pending_valid ? pending_value : cmd.cmd_value;
      end
      // a held command drains on the IDLE->LOAD hop; new ones park only while busy
      if (abort_hit || (state == ST_IDLE && pending_valid)) begin
        pending_valid <= 1'b0;
      end else if (accept && state != ST_IDLE) begin
        pending_valid <= 1'b1;
        pending_value <= cmd.cmd_value;
      end
    end
  end

`ifdef COUNTDOWN_SEQ_ABORT_EN
  always_ff @(posedge clock) begin
    if (reset) aborted <= 1'b0;
    else       aborted <= abort_hit;
  end
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// tb/tb_countdown_sequencer.sv - scoreboard bench for countdown_sequencer (abort test under COUNTDOWN_SEQ_ABORT_EN)
module tb_countdown_sequencer;
  import countdown_sequencer_pkg::*;

  localparam int W = 4;
  localparam int P = 4;

  logic clock = 1'b0;
  logic reset0 = 1'b1, reset1 = 1'b1;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  countdown_sequencer_if #(.WIDTH(W)) cif0 ();
  countdown_sequencer_if #(.WIDTH(W)) cif1 ();
  logic [W-1:0] cnt_in0, cnt_in1;
  logic latch0, dec0, busy0, done0, zero0;
  logic latch1, dec1, busy1, done1, zero1;
  logic [W-1:0] ctr0 = '0, ctr1 = '0;
`ifdef COUNTDOWN_SEQ_ABORT_EN
  logic abort0 = 1'b0, aborted0, abort1 = 1'b0, aborted1;
`endif

  // external down counters that the sequencers drive
  always @(posedge clock) begin
    if (latch0) ctr0 <= cnt_in0; else if (dec0) ctr0 <= ctr0 - 1'b1;
    if (latch1) ctr1 <= cnt_in1; else if (dec1) ctr1 <= ctr1 - 1'b1;
  end
  assign zero0 = (ctr0 == '0);
  assign zero1 = (ctr1 == '0);

  countdown_sequencer #(.WIDTH(W), .PRESCALE(P), .PS_W(4)) u_dut0 (
    .clock(clock), .reset(reset0), .cmd(cif0.slave), .cnt_in(cnt_in0),
    .cnt_latch(latch0), .cnt_dec(dec0), .cnt_zero(zero0), .busy(busy0),
`ifdef COUNTDOWN_SEQ_ABORT_EN
    .abort(abort0), .aborted(aborted0),
`endif
    .done(done0));

  countdown_sequencer #(.WIDTH(W), .PRESCALE(1), .PS_W(4)) u_dut1 (
    .clock(clock), .reset(reset1), .cmd(cif1.slave), .cnt_in(cnt_in1),
    .cnt_latch(latch1), .cnt_dec(dec1), .cnt_zero(zero1), .busy(busy1),
`ifdef COUNTDOWN_SEQ_ABORT_EN
    .abort(abort1), .aborted(aborted1),
`endif
    .done(done1));

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // reference model: per-command timeline derived from accept cycle, value and PRESCALE
  int exp_latch[$];
  int exp_lval[$];
  int exp_dec[$];
  int exp_done[$];
  int busy_lo[$];
  int busy_hi[$];
  bit have_last = 1'b0;
  int last_acc = 0, last_load = 0, last_done = -100;

  task automatic flush0();
    exp_latch.delete(); exp_lval.delete(); exp_dec.delete(); exp_done.delete();
    busy_lo.delete(); busy_hi.delete();
    have_last = 1'b0;
    last_done = -100;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      bit pred_busy;
      if (latch0) begin
        if (exp_latch.size() == 0) chk("latch_unexpected", 1, 0);
        else begin
          chk("latch_cycle", cyc, exp_latch.pop_front());
          chk("latch_value", int'(cnt_in0), exp_lval.pop_front());
        end
      end
      if (dec0) begin
        if (exp_dec.size() == 0) chk("dec_unexpected", 1, 0);
        else chk("dec_cycle", cyc, exp_dec.pop_front());
      end
      if (done0) begin
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", cyc, exp_done.pop_front());
        chk("counter_zero_at_done", int'(ctr0), 0);
      end
      if (exp_latch.size() > 0 && exp_latch[0] < cyc) begin
        chk("latch_missing", cyc, exp_latch.pop_front());
        void'(exp_lval.pop_front());
      end
      if (exp_dec.size() > 0 && exp_dec[0] < cyc) chk("dec_missing", cyc, exp_dec.pop_front());
      if (exp_done.size() > 0 && exp_done[0] < cyc) chk("done_missing", cyc, exp_done.pop_front());
      while (busy_hi.size() > 0 && busy_hi[0] < cyc) begin
        void'(busy_lo.pop_front()); void'(busy_hi.pop_front());
      end
      pred_busy = 1'b0;
      foreach (busy_lo[i]) if (busy_lo[i] <= cyc && cyc <= busy_hi[i]) pred_busy = 1'b1;
      chk("busy", int'(busy0), int'(pred_busy));
    end
  end

  task automatic send0(input int n);
    int tries = 0;
    int acc, ld, dn;
    bit pred_ready;
    cif0.cmd_valid = 1'b1;
    cif0.cmd_value = W'(n);
    forever begin
      pred_ready = !(have_last && cyc > last_acc && cyc < last_load);
      chk("cmd_ready", int'(cif0.cmd_ready), int'(pred_ready));
      if (cif0.cmd_ready === 1'b1) break;
      tries++;
      if (tries > 300) begin
        chk("ready_timeout", 0, 1);
        cif0.cmd_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    acc = cyc;
    ld  = (acc + 1 > last_done + 2) ? acc + 1 : last_done + 2;
    dn  = ld + 3 + n * P;
    exp_latch.push_back(ld); exp_lval.push_back(n);
    for (int k = 1; k <= n; k++) exp_dec.push_back(ld + 1 + k * P);
    exp_done.push_back(dn);
    busy_lo.push_back(ld); busy_hi.push_back(dn);
    have_last = 1'b1; last_acc = acc; last_load = ld; last_done = dn;
    @(posedge clock); #1;
    cif0.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
  endtask

  task automatic drain0();
    int b = 0;
    while (cyc <= last_done + 1 && b < 3000) begin @(posedge clock); #1; b++; end
    chk("leftover_latch", exp_latch.size(), 0);
    chk("leftover_dec", exp_dec.size(), 0);
    chk("leftover_done", exp_done.size(), 0);
  endtask

  task automatic check_reset_state0();
    chk("rst_busy", int'(busy0), 0);
    chk("rst_latch", int'(latch0), 0);
    chk("rst_dec", int'(dec0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_cnt_in", int'(cnt_in0), 0);
    chk("rst_ready", int'(cif0.cmd_ready), 1);
  endtask

  task automatic run1(input int n);
    int acc, lat = -1, dn = -1, ndec = 0, first = -1, last = -1;
    @(posedge clock); #1;
    chk("p1_ready", int'(cif1.cmd_ready), 1);
    cif1.cmd_valid = 1'b1;
    cif1.cmd_value = W'(n);
    acc = cyc;
    @(posedge clock); #1;
    cif1.cmd_valid = 1'b0;
    for (int t = 0; t < n + 12 && dn < 0; t++) begin
      @(negedge clock);
      if (latch1) begin lat = cyc; chk("p1_latch_value", int'(cnt_in1), n); end
      if (dec1) begin ndec++; if (first < 0) first = cyc; last = cyc; end
      if (done1) begin dn = cyc; chk("p1_counter_end", int'(ctr1), 0); end
    end
    chk("p1_latch_cycle", lat, acc + 1);
    chk("p1_dec_count", ndec, n);
    chk("p1_done_cycle", dn, acc + 4 + n);
    if (n > 0) begin
      chk("p1_first_dec", first, acc + 3);
      chk("p1_last_dec", last, acc + 2 + n);
    end
  endtask

  initial begin
    cif0.cmd_valid = 1'b0; cif0.cmd_value = '0;
    cif1.cmd_valid = 1'b0; cif1.cmd_value = '0;
    idle(3);
    reset0 = 1'b0; reset1 = 1'b0;
    check_reset_state0();
    mon_en = 1'b1;

    send0(3); drain0();
    send0(0); drain0();

    // second command parks in pending, third stalls until it drains
    send0(2);
    while (cyc < last_acc + 3) begin @(posedge clock); #1; end
    send0(1);
    send0(3);
    drain0();

    // command offered exactly in the DONE cycle
    send0(2);
    while (cyc < last_done) begin @(posedge clock); #1; end
    send0(1);
    drain0();

    for (int i = 0; i < 25; i++) begin
      idle($urandom_range(0, 20));
      send0($urandom_range(0, 15));
    end
    drain0();

    // reset in the middle of RUN
    send0(3);
    idle(4);
    reset0 = 1'b1;
    @(posedge clock); #1;
    reset0 = 1'b0;
    flush0();
    check_reset_state0();
    send0(1); drain0();

`ifdef COUNTDOWN_SEQ_ABORT_EN
    send0(7);
    idle(2);
    abort0 = 1'b1;
    @(posedge clock); #1;
    abort0 = 1'b0;
    flush0();
    chk("aborted_pulse", int'(aborted0), 1);
    chk("abort_ready", int'(cif0.cmd_ready), 1);
    idle(1);
    chk("aborted_single", int'(aborted0), 0);
    idle(40);
    send0(1); drain0();
`endif

    mon_en = 1'b0;
    run1(5);
    for (int i = 0; i < 5; i++) run1($urandom_range(0, 15));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
